mm_interrupt_redirect: RTL
==========================

// Module: mm_interrupt_redirect
// PURPOSE
//  Consumes the one-cycle trigger and handler PC from the memory-mapped interrupt
//  register block and steers the core into and out of the handler. It waits for
//  a core-signalled safe point, saves the return PC (EPC), then issues a flush plus
//  fetch redirect to the handler. On return-from-interrupt it redirects back to EPC.
//  Sits between the MMIO interrupt registers and the core fetch/commit logic.
// PARAMETERS
//  DATA_WIDTH  32  width of PCs and data
//  CNT_WIDTH   8   width of dropped-trigger counter (only with INT_DROP_CNT_EN)
// PORTS
//  clock          in   1           system clock
//  reset          in   1           synchronous, active-high reset
//  trigger_in     in   1           one-cycle interrupt request pulse from MMIO regs
//  handler_pc_in  in   DATA_WIDTH  handler PC from MMIO regs; sampled with trigger_in
//  commit_pc      in   DATA_WIDTH  PC of next instruction to commit (return target)
//  safe_point     in   1           core can be redirected this cycle
//  iret           in   1           return-from-interrupt committed this cycle
//  flush          out  1           pipeline flush pulse
//  redirect_valid out  1           fetch redirect pulse
//  redirect_pc    out  DATA_WIDTH  fetch redirect target (valid with redirect_valid)
//  int_pending    out  1           request latched, not yet taken
//  in_service     out  1           handler executing
//  epc            out  DATA_WIDTH  saved return PC
//  drop_count     out  CNT_WIDTH   dropped triggers (only with INT_DROP_CNT_EN)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0, including epc, redirect_pc, drop_count.
//    Reset wins over every other input and aborts any state, including SERVICE.
//  - FSM states: IDLE, PENDING, ENTER, SERVICE, EXIT. All outputs are registered.
//  - IDLE: if trigger_in=1, latch handler_pc_in into hpc and go to PENDING. safe_point
//    and iret are ignored in IDLE.
//  - PENDING: int_pending=1. If safe_point=1 in cycle N: epc<=commit_pc(N) and go to
//    ENTER. Otherwise wait; there is no timeout.
//  - ENTER (cycle N+1): flush=1, redirect_valid=1, redirect_pc=hpc for exactly one
//    cycle, int_pending=0. Next state is SERVICE.
//  - SERVICE: in_service=1. If iret=1 in cycle M, go to EXIT.
//  - EXIT (cycle M+1): flush=1, redirect_valid=1, redirect_pc=epc for one cycle,
//    in_service=0. Next state is IDLE.
//  - flush and redirect_valid are only ever high together, and only in ENTER and EXIT.
//  - No nesting. trigger_in in any state other than IDLE is dropped; hpc and epc
//    are unchanged.
//  - A trigger_in arriving in EXIT is dropped. The next accepted trigger is the first
//    one seen in IDLE.
//  - iret outside SERVICE is ignored.
//  - epc holds its value after EXIT until the next PENDING->ENTER transition.
//  - Latency: trigger to redirect is at least 2 cycles (IDLE->PENDING, then a
//    safe_point cycle, then ENTER). iret to redirect is 1 cycle.
// CONFIGURATION
//  - INT_DROP_CNT_EN defined: drop_count increments by 1 on each dropped trigger_in
//    and saturates at all-ones. It is cleared only by reset.
//  - INT_DROP_CNT_EN undefined: the counter logic is absent and drop_count is tied to 0.
//    The port list is identical either way.
// TESTING
//  - Basic entry: trigger_in with handler_pc_in=0x100, then safe_point 3 cycles later
//    with commit_pc=0x2040 -> one-cycle flush/redirect_valid with redirect_pc=0x100;
//    epc=0x2040; in_service=1.
//  - Return: in SERVICE, pulse iret -> next cycle flush/redirect_valid with
//    redirect_pc=0x2040, in_service=0, state IDLE.
//  - Drop: a second trigger_in (handler 0x200) during SERVICE -> no redirect, handler
//    stays 0x100 on the next entry; drop_count=1 when INT_DROP_CNT_EN is defined,
//    else 0.
//  - Ignore: iret in IDLE, and safe_point in the same cycle as trigger_in -> no flush;
//    entry happens only on a later safe_point.
//  - Reset mid-service: assert reset in SERVICE -> all outputs 0 the next cycle; a new
//    trigger is accepted normally afterwards.
//  - Saturation (macro on, CNT_WIDTH=2): 5 triggers dropped in SERVICE -> drop_count=3.

Source files
------------

// File: rtl/mm_interrupt_redirect.sv
// mm_interrupt_redirect
//   Steers the core into and out of an interrupt handler. A one-cycle trigger
//   from the MMIO interrupt registers is latched together with the handler PC.
//   The block then waits for a core safe point, saves the return PC (epc) and
//   issues a one-cycle flush plus fetch redirect to the handler. When the core
//   commits a return-from-interrupt, the block redirects fetch back to epc.
//   There is no nesting: any trigger that arrives outside IDLE is dropped.
//
//   Optional feature macro: INT_DROP_CNT_EN
//     defined   - drop_count counts dropped triggers and saturates at all-ones.
//     undefined - drop_count is tied to zero. The port list is the same.
//
// Ports
//   clock           in   system clock
//   reset           in   synchronous, active-high reset
//   trigger_in      in   one-cycle interrupt request pulse
//   handler_pc_in   in   handler PC, sampled together with trigger_in
//   commit_pc       in   PC of the next instruction to commit (return target)
//   safe_point      in   core can be redirected this cycle
//   iret            in   return-from-interrupt committed this cycle
//   flush           out  pipeline flush pulse
//   redirect_valid  out  fetch redirect pulse
//   redirect_pc     out  fetch redirect target, valid with redirect_valid
//   int_pending     out  request latched, not yet taken
//   in_service      out  handler executing
//   epc             out  saved return PC
//   drop_count      out  dropped trigger count
//
// State table
//   IDLE    | no request; waiting for trigger_in
//   PENDING | request latched; waiting for safe_point
//   ENTER   | flush + redirect to handler PC
//   SERVICE | handler executing; waiting for iret
//   EXIT    | flush + redirect back to epc

module mm_interrupt_redirect #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  trigger_in,
    input  logic [DATA_WIDTH-1:0] handler_pc_in,
    input  logic [DATA_WIDTH-1:0] commit_pc,
    input  logic                  safe_point,
    input  logic                  iret,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  int_pending,
    output logic                  in_service,
    output logic [DATA_WIDTH-1:0] epc,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PENDING = 3'd1,
        ENTER   = 3'd2,
        SERVICE = 3'd3,
        EXIT    = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] hpc;

    // Outputs are registered: each transition sets the values that belong to
    // the state being entered, so they are visible during that state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            hpc            <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            int_pending    <= 1'b0;
            in_service     <= 1'b0;
            epc            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger_in) begin
                        hpc         <= handler_pc_in;
                        int_pending <= 1'b1;
                        state       <= PENDING;
                    end
                end
                PENDING: begin
                    if (safe_point) begin
                        epc            <= commit_pc;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= hpc;
                        int_pending    <= 1'b0;
                        state          <= ENTER;
                    end
                end
                ENTER: begin
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                    in_service     <= 1'b1;
                    state          <= SERVICE;
                end
                SERVICE: begin
                    if (iret) begin
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= epc;
                        in_service     <= 1'b0;
                        state          <= EXIT;
                    end
                end
                EXIT: begin
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                    int_pending    <= 1'b0;
                    in_service     <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

`ifdef INT_DROP_CNT_EN
    // Any trigger seen outside IDLE is lost; the IDLE one is the accepted one.
    logic drop;
    assign drop = trigger_in && (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule
